// File: rtl/flush_sequencer_if.sv
// Flush sequencer bus: flush command, ROB/RAT handshakes, front-end redirect,
// stalls and stats. master = sequencer side, slave = core/peer side.
interface flush_sequencer_if #(
    parameter int ADDR_W   = 32,
    parameter int TICKET_W = 3
);
    logic                flush_valid;
    logic [ADDR_W-1:0]   flush_pc;
    logic [TICKET_W-1:0] flush_ticket;
    logic                flush_rat_id;
    logic [TICKET_W-1:0] rob_head;
    logic                rob_squash_valid;
    logic [TICKET_W-1:0] rob_squash_ticket;
    logic                rob_squash_done;
    logic                rat_restore_valid;
    logic                rat_restore_id;
    logic                rat_restore_done;
    logic                fe_redirect_valid;
    logic [ADDR_W-1:0]   fe_redirect_pc;
    logic                fe_redirect_ready;
    logic                stall_frontend;
    logic                stall_issue;
    logic                recovery_busy;
    logic [15:0]         flush_count;
    logic [7:0]          override_count;

    modport master (
        input  flush_valid, flush_pc, flush_ticket, flush_rat_id,
        input  rob_head, rob_squash_done, rat_restore_done,
        input  fe_redirect_ready,
        output rob_squash_valid, rob_squash_ticket,
        output rat_restore_valid, rat_restore_id,
        output fe_redirect_valid, fe_redirect_pc,
        output stall_frontend, stall_issue, recovery_busy,
        output flush_count, override_count
    );

    modport slave (
        output flush_valid, flush_pc, flush_ticket, flush_rat_id,
        output rob_head, rob_squash_done, rat_restore_done,
        output fe_redirect_ready,
        input  rob_squash_valid, rob_squash_ticket,
        input  rat_restore_valid, rat_restore_id,
        input  fe_redirect_valid, fe_redirect_pc,
        input  stall_frontend, stall_issue, recovery_busy,
        input  flush_count, override_count
    );
endinterface

// File: rtl/flush_sequencer.sv
// Flush sequencer: orders ROB squash + RAT restore, then front-end redirect.
// Ports: clk, rst_n (async low), bus (flush_sequencer_if.master).
// Optional stats counters: define FLUSH_SEQ_STATS_EN.
module flush_sequencer #(
    parameter int ADDR_W   = 32,
    parameter int TICKET_W = 3
) (
    input  logic clk,
    input  logic rst_n,
    flush_sequencer_if.master bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SQUASH   = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [TICKET_W-1:0] r_ticket;
    logic                r_rat_id;
    logic                r_rob_done;
    logic                r_rat_done;
    logic                r_rob_vld;
    logic                r_rat_vld;
    logic                r_fe_vld;
    logic                r_busy;

    logic [TICKET_W-1:0] w_age_new;
    logic [TICKET_W-1:0] w_age_held;
    logic                w_preempt;
    logic                w_accept;
    logic                w_rob_done_nx;
    logic                w_rat_done_nx;

    // Age relative to ROB head; modular subtraction handles wrap.
    assign w_age_new  = bus.flush_ticket - bus.rob_head;
    assign w_age_held = r_ticket - bus.rob_head;
    assign w_preempt  = bus.flush_valid && (r_state != IDLE) &&
                        (w_age_new < w_age_held);
    assign w_accept   = (bus.flush_valid && (r_state == IDLE)) ||
                        w_preempt;

    // Done strobes only count while the matching request is up.
    assign w_rob_done_nx = r_rob_done | (bus.rob_squash_done & r_rob_vld);
    assign w_rat_done_nx = r_rat_done | (bus.rat_restore_done & r_rat_vld);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pc       <= '0;
            r_ticket   <= '0;
            r_rat_id   <= 1'b0;
            r_rob_done <= 1'b0;
            r_rat_done <= 1'b0;
            r_rob_vld  <= 1'b0;
            r_rat_vld  <= 1'b0;
            r_fe_vld   <= 1'b0;
            r_busy     <= 1'b0;
        end else if (w_accept) begin
            // Fresh capture and preemption share one path; it also
            // wins over a redirect handshake completing this cycle.
            r_state    <= SQUASH;
            r_pc       <= bus.flush_pc;
            r_ticket   <= bus.flush_ticket;
            r_rat_id   <= bus.flush_rat_id;
            r_rob_done <= 1'b0;
            r_rat_done <= 1'b0;
            r_rob_vld  <= 1'b1;
            r_rat_vld  <= 1'b1;
            r_fe_vld   <= 1'b0;
            r_busy     <= 1'b1;
        end else begin
            unique case (r_state)
                SQUASH: begin
                    r_rob_done <= w_rob_done_nx;
                    r_rat_done <= w_rat_done_nx;
                    r_rob_vld  <= !w_rob_done_nx;
                    r_rat_vld  <= !w_rat_done_nx;
                    if (w_rob_done_nx && w_rat_done_nx) begin
                        r_state  <= REDIRECT;
                        r_fe_vld <= 1'b1;
                    end
                end
                REDIRECT: begin
                    if (bus.fe_redirect_ready) begin
                        r_state  <= IDLE;
                        r_fe_vld <= 1'b0;
                        r_busy   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.rob_squash_valid  = r_rob_vld;
    assign bus.rob_squash_ticket = r_ticket;
    assign bus.rat_restore_valid = r_rat_vld;
    assign bus.rat_restore_id    = r_rat_id;
    assign bus.fe_redirect_valid = r_fe_vld;
    assign bus.fe_redirect_pc    = r_pc;
    assign bus.stall_frontend    = r_busy;
    assign bus.stall_issue       = r_busy;
    assign bus.recovery_busy     = r_busy;

`ifdef FLUSH_SEQ_STATS_EN
    logic [15:0] r_flush_cnt;
    logic [7:0]  r_ovr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flush_cnt <= '0;
            r_ovr_cnt   <= '0;
        end else begin
            if (w_accept && (r_flush_cnt != 16'hFFFF))
                r_flush_cnt <= r_flush_cnt + 16'd1;
            if (w_preempt && (r_ovr_cnt != 8'hFF))
                r_ovr_cnt <= r_ovr_cnt + 8'd1;
        end
    end

    assign bus.flush_count    = r_flush_cnt;
    assign bus.override_count = r_ovr_cnt;
`else
    assign bus.flush_count    = '0;
    assign bus.override_count = '0;
`endif
endmodule

// File: tb/tb_flush_sequencer.sv
// Directed self-checking bench for flush_sequencer.
// Inputs driven and outputs sampled 1ns after the rising edge.
module tb_flush_sequencer;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

`ifdef FLUSH_SEQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    flush_sequencer_if #(.ADDR_W(32), .TICKET_W(3)) bus ();

    flush_sequencer #(.ADDR_W(32), .TICKET_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flush(input logic [31:0] pc, input logic [2:0] tk,
                         input logic id, input logic [2:0] head);
        bus.flush_valid  = 1'b1;
        bus.flush_pc     = pc;
        bus.flush_ticket = tk;
        bus.flush_rat_id = id;
        bus.rob_head     = head;
    endtask

    task automatic clr();
        bus.flush_valid       = 1'b0;
        bus.rob_squash_done   = 1'b0;
        bus.rat_restore_done  = 1'b0;
        bus.fe_redirect_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_tests++;
        if ({bus.rob_squash_valid, bus.rat_restore_valid,
             bus.fe_redirect_valid, bus.recovery_busy} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_valids got %b exp 0000",
                {bus.rob_squash_valid, bus.rat_restore_valid,
                 bus.fe_redirect_valid, bus.recovery_busy});
        end
        n_tests++;
        if (bus.fe_redirect_pc !== 32'h0 || bus.rob_squash_ticket !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_data got pc=%h tk=%0d exp 0",
                bus.fe_redirect_pc, bus.rob_squash_ticket);
        end
        n_tests++;
        if (bus.flush_count !== 16'd0 || bus.override_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_cnt got %0d/%0d exp 0/0",
                bus.flush_count, bus.override_count);
        end
    endtask

    task automatic test_basic();
        flush(32'h100, 3'd2, 1'b1, 3'd0);
        step(); clr();
        n_tests++;
        if ({bus.rob_squash_valid, bus.rat_restore_valid,
             bus.fe_redirect_valid, bus.stall_frontend} !== 4'b1101) begin
            n_fail++;
            $display("FAIL basic_t1 got %b exp 1101",
                {bus.rob_squash_valid, bus.rat_restore_valid,
                 bus.fe_redirect_valid, bus.stall_frontend});
        end
        n_tests++;
        if (bus.rob_squash_ticket !== 3'd2 || bus.rat_restore_id !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_ids got tk=%0d id=%0d exp 2/1",
                bus.rob_squash_ticket, bus.rat_restore_id);
        end
        bus.rob_squash_done  = 1'b1;
        bus.rat_restore_done = 1'b1;
        step(); clr();
        n_tests++;
        if ({bus.rob_squash_valid, bus.rat_restore_valid,
             bus.fe_redirect_valid} !== 3'b001 ||
            bus.fe_redirect_pc !== 32'h100) begin
            n_fail++;
            $display("FAIL basic_t2 got %b pc=%h exp 001 pc=100",
                {bus.rob_squash_valid, bus.rat_restore_valid,
                 bus.fe_redirect_valid}, bus.fe_redirect_pc);
        end
        bus.fe_redirect_ready = 1'b1;
        step(); clr();
        n_tests++;
        if (bus.recovery_busy !== 1'b0 || bus.fe_redirect_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_t3 got busy=%b fe=%b exp 0/0",
                bus.recovery_busy, bus.fe_redirect_valid);
        end
        n_tests++;
        if (bus.flush_count !== (STATS ? 16'd1 : 16'd0)) begin
            n_fail++;
            $display("FAIL basic_cnt got %0d exp %0d",
                bus.flush_count, STATS ? 1 : 0);
        end
    endtask

    task automatic test_stray_done();
        bus.rob_squash_done  = 1'b1;
        bus.rat_restore_done = 1'b1;
        step(); clr(); step();
        n_tests++;
        if (bus.recovery_busy !== 1'b0 || bus.fe_redirect_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_done got busy=%b fe=%b exp 0/0",
                bus.recovery_busy, bus.fe_redirect_valid);
        end
    endtask

    task automatic test_skewed();
        flush(32'h180, 3'd3, 1'b0, 3'd0);
        step(); clr();
        bus.rat_restore_done = 1'b1;
        step(); clr();
        n_tests++;
        if (bus.rat_restore_valid !== 1'b0 || bus.rob_squash_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL skew_t2 got rat=%b rob=%b exp 0/1",
                bus.rat_restore_valid, bus.rob_squash_valid);
        end
        step(); step(); step();
        n_tests++;
        if (bus.rob_squash_valid !== 1'b1 || bus.fe_redirect_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL skew_t5 got rob=%b fe=%b exp 1/0",
                bus.rob_squash_valid, bus.fe_redirect_valid);
        end
        bus.rob_squash_done = 1'b1;
        step(); clr();
        n_tests++;
        if (bus.rob_squash_valid !== 1'b0 || bus.fe_redirect_valid !== 1'b1 ||
            bus.fe_redirect_pc !== 32'h180) begin
            n_fail++;
            $display("FAIL skew_t6 got rob=%b fe=%b pc=%h exp 0/1/180",
                bus.rob_squash_valid, bus.fe_redirect_valid,
                bus.fe_redirect_pc);
        end
        bus.fe_redirect_ready = 1'b1;
        step(); clr();
    endtask

    task automatic test_preempt_older();
        flush(32'h300, 3'd5, 1'b0, 3'd4);
        step(); clr();
        bus.rat_restore_done = 1'b1;
        step(); clr();
        flush(32'h200, 3'd4, 1'b1, 3'd4);
        step(); clr();
        n_tests++;
        if ({bus.rob_squash_valid, bus.rat_restore_valid} !== 2'b11 ||
            bus.rob_squash_ticket !== 3'd4 || bus.rat_restore_id !== 1'b1) begin
            n_fail++;
            $display("FAIL preempt_recap got v=%b tk=%0d id=%b exp 11/4/1",
                {bus.rob_squash_valid, bus.rat_restore_valid},
                bus.rob_squash_ticket, bus.rat_restore_id);
        end
        n_tests++;
        if (bus.override_count !== (STATS ? 8'd1 : 8'd0)) begin
            n_fail++;
            $display("FAIL preempt_ovr got %0d exp %0d",
                bus.override_count, STATS ? 1 : 0);
        end
        bus.rob_squash_done  = 1'b1;
        bus.rat_restore_done = 1'b1;
        step(); clr();
        n_tests++;
        if (bus.fe_redirect_valid !== 1'b1 || bus.fe_redirect_pc !== 32'h200) begin
            n_fail++;
            $display("FAIL preempt_pc got fe=%b pc=%h exp 1/200",
                bus.fe_redirect_valid, bus.fe_redirect_pc);
        end
        bus.fe_redirect_ready = 1'b1;
        step(); clr();
    endtask

    task automatic test_drop_younger();
        flush(32'h400, 3'd7, 1'b0, 3'd6);
        step(); clr();
        flush(32'h500, 3'd0, 1'b1, 3'd6);
        step(); clr();
        n_tests++;
        if (bus.rob_squash_ticket !== 3'd7 || bus.rat_restore_id !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_hold got tk=%0d id=%b exp 7/0",
                bus.rob_squash_ticket, bus.rat_restore_id);
        end
        bus.rob_squash_done  = 1'b1;
        bus.rat_restore_done = 1'b1;
        step(); clr();
        n_tests++;
        if (bus.fe_redirect_pc !== 32'h400) begin
            n_fail++;
            $display("FAIL drop_pc got %h exp 400", bus.fe_redirect_pc);
        end
        n_tests++;
        if (bus.flush_count !== (STATS ? 16'd5 : 16'd0) ||
            bus.override_count !== (STATS ? 8'd1 : 8'd0)) begin
            n_fail++;
            $display("FAIL drop_cnt got %0d/%0d exp %0d/%0d",
                bus.flush_count, bus.override_count,
                STATS ? 5 : 0, STATS ? 1 : 0);
        end
        bus.fe_redirect_ready = 1'b1;
        step(); clr();
    endtask

    task automatic test_backpressure();
        flush(32'h600, 3'd1, 1'b0, 3'd0);
        step(); clr();
        bus.rob_squash_done  = 1'b1;
        bus.rat_restore_done = 1'b1;
        step(); clr();
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if ({bus.fe_redirect_valid, bus.stall_frontend,
                 bus.stall_issue} !== 3'b111 ||
                bus.fe_redirect_pc !== 32'h600) begin
                n_fail++;
                $display("FAIL bp_hold[%0d] got %b pc=%h exp 111/600", i,
                    {bus.fe_redirect_valid, bus.stall_frontend,
                     bus.stall_issue}, bus.fe_redirect_pc);
            end
            step();
        end
        bus.fe_redirect_ready = 1'b1;
        step(); clr();
        n_tests++;
        if ({bus.fe_redirect_valid, bus.stall_frontend,
             bus.stall_issue} !== 3'b000) begin
            n_fail++;
            $display("FAIL bp_exit got %b exp 000",
                {bus.fe_redirect_valid, bus.stall_frontend,
                 bus.stall_issue});
        end
    endtask

    task automatic test_preempt_vs_ready();
        flush(32'h700, 3'd3, 1'b0, 3'd0);
        step(); clr();
        bus.rob_squash_done  = 1'b1;
        bus.rat_restore_done = 1'b1;
        step(); clr();
        flush(32'h710, 3'd1, 1'b1, 3'd0);
        bus.fe_redirect_ready = 1'b1;
        step(); clr();
        n_tests++;
        if ({bus.recovery_busy, bus.rob_squash_valid,
             bus.fe_redirect_valid} !== 3'b110 ||
            bus.rob_squash_ticket !== 3'd1) begin
            n_fail++;
            $display("FAIL pvr_state got %b tk=%0d exp 110/1",
                {bus.recovery_busy, bus.rob_squash_valid,
                 bus.fe_redirect_valid}, bus.rob_squash_ticket);
        end
        n_tests++;
        if (bus.flush_count !== (STATS ? 16'd8 : 16'd0) ||
            bus.override_count !== (STATS ? 8'd2 : 8'd0)) begin
            n_fail++;
            $display("FAIL pvr_cnt got %0d/%0d exp %0d/%0d",
                bus.flush_count, bus.override_count,
                STATS ? 8 : 0, STATS ? 2 : 0);
        end
        bus.rob_squash_done  = 1'b1;
        bus.rat_restore_done = 1'b1;
        step(); clr();
        n_tests++;
        if (bus.fe_redirect_pc !== 32'h710) begin
            n_fail++;
            $display("FAIL pvr_pc got %h exp 710", bus.fe_redirect_pc);
        end
    endtask

    task automatic test_reset_mid();
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.fe_redirect_valid, bus.recovery_busy,
             bus.stall_issue} !== 3'b000 ||
            bus.fe_redirect_pc !== 32'h0 || bus.flush_count !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_mid got %b pc=%h cnt=%0d exp 000/0/0",
                {bus.fe_redirect_valid, bus.recovery_busy,
                 bus.stall_issue}, bus.fe_redirect_pc, bus.flush_count);
        end
        step();
        rst_n = 1'b1;
        step(); step();
        n_tests++;
        if (bus.recovery_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_idle got busy=%b exp 0", bus.recovery_busy);
        end
        flush(32'h800, 3'd2, 1'b0, 3'd0);
        step(); clr();
        n_tests++;
        if (bus.recovery_busy !== 1'b1 || bus.rob_squash_ticket !== 3'd2) begin
            n_fail++;
            $display("FAIL rst_reflush got busy=%b tk=%0d exp 1/2",
                bus.recovery_busy, bus.rob_squash_ticket);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        clr();
        bus.flush_pc     = '0;
        bus.flush_ticket = '0;
        bus.flush_rat_id = 1'b0;
        bus.rob_head     = '0;
        #23;
        test_reset();
        rst_n = 1'b1;
        step();
        test_basic();
        test_stray_done();
        test_skewed();
        test_preempt_older();
        test_drop_younger();
        test_backpressure();
        test_preempt_vs_ready();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
